// File: rtl/pitch_lookup_mc.sv
// Multi-channel pitch lookup: serialises per-voice note requests onto one
// synchronous pitch ROM with a round-robin arbiter. Each lookup reads a high
// and a low 16-bit word, forms a 32-bit phase delta and adds the channel's
// signed detune. Results are held per channel and announced with a one-cycle
// valid pulse.
module pitch_lookup_mc #(
    parameter int CHANNELS = 4,
    parameter int PITCH_W  = 6,
    parameter int ROM_AW   = 8,
    parameter int ROM_DW   = 16,
    parameter int DETUNE_W = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_enable,
    input  logic [CHANNELS-1:0]            i_req,
    input  logic [CHANNELS*PITCH_W-1:0]    i_pitch,
    input  logic [CHANNELS*DETUNE_W-1:0]   i_detune,
    output logic                           o_busy,
    output logic [CHANNELS-1:0]            o_valid,
    output logic [CHANNELS*2*ROM_DW-1:0]   o_phase_delta,
    output logic [ROM_AW-1:0]              o_rom_addr,
    input  logic [ROM_DW-1:0]              i_rom_data
);

    localparam int DW2 = 2 * ROM_DW;
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_HI,
        S_READ_LO,
        S_CAPTURE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [CHANNELS-1:0] w_pend;
    logic [PITCH_W-1:0]  w_lat_pitch [CHANNELS];
    logic [DETUNE_W-1:0] w_lat_det   [CHANNELS];

    logic                w_found;
    logic [CW-1:0]       w_gnt_idx;
    logic                w_grant;

    logic [CW-1:0]       r_ptr;
    logic [CW-1:0]       r_gnt;
    logic [PITCH_W-1:0]  r_pitch;
    logic [DETUNE_W-1:0] r_det;
    logic [ROM_DW-1:0]   r_hi;
    logic [DW2-1:0]      w_sum;

    // Word address of a note: hi word at even, lo word at odd, zero-extended.
    function automatic logic [ROM_AW-1:0] f_addr(input logic [PITCH_W-1:0] p,
                                                 input logic lsb);
        return ROM_AW'({p, lsb});
    endfunction

    // Round-robin search: first pending channel at or after the pointer.
    always_comb begin
        int idx;
        idx       = 0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(r_ptr) + k) % CHANNELS;
            if (!w_found && w_pend[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = CW'(idx);
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && i_enable && w_found;
    assign o_busy  = (r_state != S_IDLE);

    // High word from the earlier read, low word arriving now, plus detune.
    assign w_sum = {r_hi, i_rom_data} +
                   {{(DW2-DETUNE_W){r_det[DETUNE_W-1]}}, r_det};

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: fixed four-step walk once a grant is made.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_grant) w_state_next = S_READ_HI;
            S_READ_HI: w_state_next = S_READ_LO;
            S_READ_LO: w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Lookup datapath: grant snapshot, ROM addressing, hi capture, pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_pitch    <= '0;
            r_det      <= '0;
            r_hi       <= '0;
            o_rom_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt      <= w_gnt_idx;
                        r_pitch    <= w_lat_pitch[w_gnt_idx];
                        r_det      <= w_lat_det[w_gnt_idx];
                        o_rom_addr <= f_addr(w_lat_pitch[w_gnt_idx], 1'b0);
                    end
                end
                S_READ_HI: o_rom_addr <= f_addr(r_pitch, 1'b1);
                S_READ_LO: r_hi <= i_rom_data;
                S_CAPTURE: r_ptr <= (r_gnt == CW'(CHANNELS-1)) ? '0 : r_gnt + 1'b1;
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic                r_pend;
            logic [PITCH_W-1:0]  r_lat_pitch;
            logic [DETUNE_W-1:0] r_lat_det;
            logic                r_valid;
            logic [DW2-1:0]      r_delta;
            logic                w_take;
            logic                w_done;

            assign w_take = w_grant && (w_gnt_idx == CW'(gi));
            assign w_done = (r_state == S_CAPTURE) && (r_gnt == CW'(gi));

            // Request capture; a new request wins over clearing on grant.
            always_ff @(posedge i_clk) begin
                if (!i_rst) begin
                    r_pend      <= 1'b0;
                    r_lat_pitch <= '0;
                    r_lat_det   <= '0;
                end else if (i_req[gi]) begin
                    r_pend      <= 1'b1;
                    r_lat_pitch <= i_pitch[gi*PITCH_W +: PITCH_W];
                    r_lat_det   <= i_detune[gi*DETUNE_W +: DETUNE_W];
                end else if (w_take) begin
                    r_pend      <= 1'b0;
                end
            end

            // Per-channel result register and its one-cycle update pulse.
            always_ff @(posedge i_clk) begin
                if (!i_rst) begin
                    r_valid <= 1'b0;
                    r_delta <= '0;
                end else begin
                    r_valid <= w_done;
                    if (w_done) begin
                        r_delta <= w_sum;
                    end
                end
            end

            assign w_pend[gi]                     = r_pend;
            assign w_lat_pitch[gi]                = r_lat_pitch;
            assign w_lat_det[gi]                  = r_lat_det;
            assign o_valid[gi]                    = r_valid;
            assign o_phase_delta[gi*DW2 +: DW2]   = r_delta;
        end
    endgenerate

endmodule

// File: tb/tb_pitch_lookup_mc.sv
// Bench for pitch_lookup_mc: directed requests push expected (channel, delta,
// cycle) entries into a scoreboard; a monitor pops one per valid pulse.
module tb_pitch_lookup_mc;

    localparam int CH = 4;
    localparam int PW = 6;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [CH-1:0]     req_bus;
    logic [CH*PW-1:0]  pitch_bus;
    logic [CH*TW-1:0]  det_bus;
    logic              busy;
    logic [CH-1:0]     valid;
    logic [CH*32-1:0]  delta_bus;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;

    logic [DW-1:0]     mem [256];

    typedef struct {
        int          ch;
        logic [31:0] delta;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   e0;

    pitch_lookup_mc #(
        .CHANNELS(CH), .PITCH_W(PW), .ROM_AW(AW), .ROM_DW(DW), .DETUNE_W(TW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_enable(enable),
        .i_req(req_bus),
        .i_pitch(pitch_bus),
        .i_detune(det_bus),
        .o_busy(busy),
        .o_valid(valid),
        .o_phase_delta(delta_bus),
        .o_rom_addr(rom_addr),
        .i_rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the number of the latest posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM model.
    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic issue(input int c, input int p, input int d);
        req_bus[c]            = 1'b1;
        pitch_bus[c*PW +: PW] = PW'(p);
        det_bus[c*TW +: TW]   = TW'(d);
    endtask

    task automatic push(input int c, input logic [31:0] d, input int at);
        q.push_back('{ch: c, delta: d, cyc: at});
    endtask

    task automatic do_reset();
        req_bus = '0;
        rst     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every valid pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (valid[c]) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got pulse on ch%0d at cycle %0d, required none", c, cyc);
                end else begin
                    e = q.pop_front();
                    chk("valid_channel", 32'(c), 32'(e.ch));
                    chk("phase_delta", delta_bus[c*32 +: 32], e.delta);
                    chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                    $display("txn ch%0d delta %h cycle %0d", c, delta_bus[c*32 +: 32], cyc);
                end
            end
        end
    end

    initial begin
        for (int p = 0; p < 128; p++) begin
            mem[2*p]   = 16'h0100 + 16'(p);
            mem[2*p+1] = 16'hA000 + 16'(p);
        end
        mem[0] = 16'h0000;
        mem[1] = 16'h0000;
        for (int a = 256; a < 256; a++) mem[a] = '0;

        rst = 1'b0; enable = 1'b1; req_bus = '0; pitch_bus = '0; det_bus = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_addr", 32'(rom_addr), 32'h0);
        for (int c = 0; c < CH; c++) chk("reset_delta", delta_bus[c*32 +: 32], 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single channel: ch1 pitch 5, no detune.
        e0 = cyc + 1;
        issue(1, 5, 0);
        push(1, 32'h0105A005, e0 + 4);
        @(negedge clk); req_bus = '0;
        repeat (7) @(negedge clk);
        chk("idle_ch0_delta", delta_bus[0 +: 32], 32'h0);
        chk("idle_ch2_delta", delta_bus[64 +: 32], 32'h0);
        chk("idle_ch3_delta", delta_bus[96 +: 32], 32'h0);

        // Detune wrap on a zero ROM entry: -1 and +3.
        e0 = cyc + 1;
        issue(0, 0, -1);
        push(0, 32'hFFFFFFFF, e0 + 4);
        @(negedge clk); req_bus = '0;
        repeat (6) @(negedge clk);
        e0 = cyc + 1;
        issue(0, 0, 3);
        push(0, 32'h00000003, e0 + 4);
        @(negedge clk); req_bus = '0;
        repeat (6) @(negedge clk);
        chk("ch1_held", delta_bus[32 +: 32], 32'h0105A005);

        // All four channels at once: serviced in order, 4 cycles apart.
        do_reset();
        e0 = cyc + 1;
        for (int c = 0; c < CH; c++) issue(c, c + 1, 0);
        push(0, 32'h0101A001, e0 + 4);
        push(1, 32'h0102A002, e0 + 8);
        push(2, 32'h0103A003, e0 + 12);
        push(3, 32'h0104A004, e0 + 16);
        @(negedge clk); req_bus = '0;
        repeat (20) @(negedge clk);

        // Fairness: ch0 requests continuously for 8 edges, ch2 once.
        do_reset();
        e0 = cyc + 1;
        issue(0, 10, 0);
        issue(2, 20, 5);
        push(0, 32'h010AA00A, e0 + 4);
        push(2, 32'h0114A019, e0 + 8);
        push(0, 32'h010AA00A, e0 + 12);
        @(negedge clk); req_bus[2] = 1'b0;
        repeat (7) @(negedge clk);
        req_bus = '0;
        repeat (10) @(negedge clk);

        // Re-request while in service: two pulses, final pitch 9.
        do_reset();
        e0 = cyc + 1;
        issue(3, 7, 0);
        push(3, 32'h0107A007, e0 + 4);
        push(3, 32'h0109A009, e0 + 8);
        @(negedge clk); req_bus = '0;
        @(negedge clk);
        issue(3, 9, 0);
        @(negedge clk); req_bus = '0;
        repeat (10) @(negedge clk);
        chk("rerequest_final", delta_bus[96 +: 32], 32'h0109A009);

        // Reset during READ_LO aborts the lookup with no pulse.
        e0 = cyc + 1;
        issue(1, 5, 0);
        @(negedge clk); req_bus = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_addr", 32'(rom_addr), 32'h0);
        for (int c = 0; c < CH; c++) chk("abort_delta", delta_bus[c*32 +: 32], 32'h0);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // Enable low holds the request pending; raising it grants at once.
        enable = 1'b0;
        issue(2, 6, 0);
        @(negedge clk); req_bus = '0;
        repeat (6) begin
            @(negedge clk);
            chk("disabled_busy", 32'(busy), 32'h0);
            chk("disabled_valid", 32'(valid), 32'h0);
        end
        e0 = cyc + 1;
        push(2, 32'h0106A006, e0 + 3);
        enable = 1'b1;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
